// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the Hack PC: drives PC strobes, the ROM request/ack
// handshake, the per-instruction CPU write enable, and run/step/halt/breakpoint debug control.
module pc_sequencer #(
  parameter bit          AUTORUN = 1'b0,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        pc,
  input  logic               rom_ack,
  input  logic [15:0]        instr_rd,
  input  logic               jump,
  input  logic [15:0]        jump_target,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic               restart,
  input  logic               bp_en,
  input  logic [15:0]        bp_addr,
  output logic [15:0]        pc_in,
  output logic               pc_load,
  output logic               pc_inc,
  output logic               pc_reset,
  output logic               rom_req,
  output logic [15:0]        instr,
  output logic               exec_en,
  output logic               halted,
  output logic               bp_hit,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_HALT  = 2'd1,
    ST_FETCH = 2'd2,
    ST_EXEC  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic                 run_mode_r, run_mode_s;
  logic                 bp_hit_r, bp_hit_s;
  logic [15:0]          instr_r, instr_s;
  logic [COUNT_W-1:0]   retired_r, retired_s;
  logic [15:0]          next_pc_s;
  logic                 bp_match_s;

  assign next_pc_s  = jump ? jump_target : (pc + 16'd1);
  assign bp_match_s = bp_en && (next_pc_s == bp_addr);

  assign instr   = instr_r;
  assign bp_hit  = bp_hit_r;
  assign retired = retired_r;

  // Next-state, register updates and state-decoded strobes.
  always_comb begin
    state_s    = state_r;
    run_mode_s = run_mode_r;
    bp_hit_s   = bp_hit_r;
    instr_s    = instr_r;
    retired_s  = retired_r;
    pc_in      = 16'h0000;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_reset   = 1'b0;
    rom_req    = 1'b0;
    exec_en    = 1'b0;
    halted     = 1'b0;

    case (state_r)
      ST_INIT: begin
        pc_reset   = 1'b1;
        retired_s  = {COUNT_W{1'b0}};
        bp_hit_s   = 1'b0;
        run_mode_s = AUTORUN;
        state_s    = AUTORUN ? ST_FETCH : ST_HALT;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          run_mode_s = 1'b1;
          bp_hit_s   = 1'b0;
          state_s    = ST_FETCH;
        end else if (step) begin
          run_mode_s = 1'b0;
          bp_hit_s   = 1'b0;
          state_s    = ST_FETCH;
        end else begin
          state_s    = ST_HALT;
        end
      end
      ST_FETCH: begin
        rom_req = 1'b1;
        if (rom_ack) begin
          instr_s = instr_rd;
          state_s = ST_EXEC;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        exec_en   = 1'b1;
        pc_in     = jump_target;
        pc_load   = jump;
        pc_inc    = !jump;
        retired_s = retired_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        if (bp_match_s) begin
          bp_hit_s = 1'b1;
        end else begin
          bp_hit_s = bp_hit_r;
        end
        if (halt_req || !run_mode_r || bp_match_s) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase

    // restart overrides everything: the current instruction neither commits nor counts.
    if (restart) begin
      state_s    = ST_INIT;
      run_mode_s = run_mode_r;
      bp_hit_s   = bp_hit_r;
      instr_s    = instr_r;
      retired_s  = retired_r;
      exec_en    = 1'b0;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
    end else begin
      state_s    = state_s;
    end

    // Strobes must stay quiet while reset holds the state in INIT.
    if (reset) begin
      pc_in    = 16'h0000;
      pc_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_reset = 1'b0;
      rom_req  = 1'b0;
      exec_en  = 1'b0;
      halted   = 1'b0;
    end else begin
      halted   = halted;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_INIT;
      run_mode_r <= 1'b0;
      bp_hit_r   <= 1'b0;
      instr_r    <= 16'h0000;
      retired_r  <= {COUNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      run_mode_r <= run_mode_s;
      bp_hit_r   <= bp_hit_s;
      instr_r    <= instr_s;
      retired_r  <= retired_s;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (AUTORUN=0) with a behavioural PC register.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        rom_ack = 1'b0;
  logic [15:0] instr_rd = 16'h0000;
  logic        jump = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic        run = 1'b0, step = 1'b0, halt_req = 1'b0, restart = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'h0000;
  logic [15:0] pc_in;
  logic        pc_load, pc_inc, pc_reset, rom_req, exec_en, halted, bp_hit;
  logic [15:0] instr;
  logic [31:0] retired;
  logic        pc_preset_en = 1'b0;
  logic [15:0] pc_preset_val = 16'h0000;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(.AUTORUN(1'b0), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .pc(pc), .rom_ack(rom_ack), .instr_rd(instr_rd),
    .jump(jump), .jump_target(jump_target), .run(run), .step(step),
    .halt_req(halt_req), .restart(restart), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc_in(pc_in), .pc_load(pc_load), .pc_inc(pc_inc), .pc_reset(pc_reset),
    .rom_req(rom_req), .instr(instr), .exec_en(exec_en), .halted(halted),
    .bp_hit(bp_hit), .retired(retired)
  );

  always #5 clk = ~clk;

  // PC register model obeying the strobes.
  always @(posedge clk) begin
    if (pc_preset_en)  pc <= pc_preset_val;
    else if (pc_reset) pc <= 16'h0000;
    else if (pc_load)  pc <= pc_in;
    else if (pc_inc)   pc <= pc + 16'd1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++; if (pc_reset !== 1'b0 || halted !== 1'b0 || rom_req !== 1'b0) begin $display("FAIL reset_strobes: got rst=%b hlt=%b req=%b exp 0 0 0", pc_reset, halted, rom_req); fails++; end
    tests++; if (retired !== 32'd0 || instr !== 16'h0000 || bp_hit !== 1'b0) begin $display("FAIL reset_regs: got ret=%0d instr=%h bp=%b exp 0", retired, instr, bp_hit); fails++; end
    next_cycle(); reset = 1'b0; #1;
    tests++; if (pc_reset !== 1'b1 || halted !== 1'b0) begin $display("FAIL init_pc_reset: got rst=%b hlt=%b exp 1 0", pc_reset, halted); fails++; end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      tests++; if (halted !== 1'b1 || rom_req !== 1'b0 || pc_reset !== 1'b0) begin $display("FAIL halt_idle: cyc %0d got hlt=%b req=%b rst=%b exp 1 0 0", i, halted, rom_req, pc_reset); fails++; end
    end
  endtask

  task automatic test_step_late_ack();
    int reqs;
    reqs = 0;
    step = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); step = 1'b0;
      rom_ack = (i == 2); instr_rd = 16'h0010; #1;
      if (rom_req === 1'b1) reqs++;
    end
    tests++; if (reqs !== 3) begin $display("FAIL step_req_len: got %0d exp 3", reqs); fails++; end
    next_cycle(); rom_ack = 1'b0; instr_rd = 16'h0000; jump = 1'b0; jump_target = 16'h1234; #1;
    tests++; if (exec_en !== 1'b1 || pc_inc !== 1'b1 || pc_load !== 1'b0) begin $display("FAIL step_exec: got en=%b inc=%b ld=%b exp 1 1 0", exec_en, pc_inc, pc_load); fails++; end
    tests++; if (instr !== 16'h0010 || pc_in !== 16'h1234) begin $display("FAIL step_instr: got instr=%h pc_in=%h exp 0010 1234", instr, pc_in); fails++; end
    next_cycle(); #1;
    tests++; if (halted !== 1'b1 || retired !== 32'd1 || exec_en !== 1'b0 || pc !== 16'h0001) begin $display("FAIL step_done: got hlt=%b ret=%0d en=%b pc=%h exp 1 1 0 0001", halted, retired, exec_en, pc); fails++; end
  endtask

  task automatic test_run_jump();
    run = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); run = 1'b0; rom_ack = 1'b1; instr_rd = 16'h0100 + 16'(i); halt_req = (i == 1); #1;
      tests++; if (rom_req !== 1'b1 || exec_en !== 1'b0 || pc_inc !== 1'b0 || pc_load !== 1'b0) begin $display("FAIL run_fetch%0d: got req=%b en=%b inc=%b ld=%b exp 1 0 0 0", i, rom_req, exec_en, pc_inc, pc_load); fails++; end
      next_cycle(); rom_ack = 1'b0; halt_req = (i == 3); jump = (i == 3);
      jump_target = (i == 3) ? 16'h0005 : 16'hBEEF; #1;
      tests++; if (exec_en !== 1'b1 || pc_load !== (i == 3) || pc_inc !== (i != 3) || instr !== 16'h0100 + 16'(i)) begin $display("FAIL run_exec%0d: got en=%b ld=%b inc=%b instr=%h", i, exec_en, pc_load, pc_inc, instr); fails++; end
      if (i == 3) begin
        tests++; if (pc_in !== 16'h0005) begin $display("FAIL run_jump_pc_in: got %h exp 0005", pc_in); fails++; end
      end
    end
    next_cycle(); jump = 1'b0; halt_req = 1'b0; #1;
    tests++; if (halted !== 1'b1 || retired !== 32'd5 || pc !== 16'h0005) begin $display("FAIL run_done: got hlt=%b ret=%0d pc=%h exp 1 5 0005", halted, retired, pc); fails++; end
  endtask

  task automatic test_breakpoint();
    int execs, n;
    execs = 0;
    restart = 1'b1; #1;
    next_cycle(); restart = 1'b0; #1;
    tests++; if (pc_reset !== 1'b1) begin $display("FAIL restart_init: got pc_reset=%b exp 1", pc_reset); fails++; end
    next_cycle(); #1;
    tests++; if (halted !== 1'b1 || retired !== 32'd0 || pc !== 16'h0000) begin $display("FAIL restart_clear: got hlt=%b ret=%0d pc=%h exp 1 0 0000", halted, retired, pc); fails++; end
    bp_en = 1'b1; bp_addr = 16'h0003; run = 1'b1; #1;
    for (n = 0; n < 40; n++) begin
      next_cycle(); run = 1'b0; rom_ack = 1'b1; #1;
      if (exec_en === 1'b1) execs++;
      if (halted === 1'b1) break;
    end
    rom_ack = 1'b0;
    tests++; if (n >= 40 || execs !== 3) begin $display("FAIL bp_stop: got execs=%0d cycles=%0d exp 3 execs", execs, n); fails++; end
    tests++; if (retired !== 32'd3 || bp_hit !== 1'b1 || pc !== 16'h0003) begin $display("FAIL bp_state: got ret=%0d bp=%b pc=%h exp 3 1 0003", retired, bp_hit, pc); fails++; end
    step = 1'b1; #1;
    next_cycle(); step = 1'b0; rom_ack = 1'b1; #1;
    tests++; if (bp_hit !== 1'b0 || rom_req !== 1'b1) begin $display("FAIL bp_step_clear: got bp=%b req=%b exp 0 1", bp_hit, rom_req); fails++; end
    next_cycle(); rom_ack = 1'b0; #1;
    tests++; if (exec_en !== 1'b1 || pc_inc !== 1'b1) begin $display("FAIL bp_step_exec: got en=%b inc=%b exp 1 1", exec_en, pc_inc); fails++; end
    next_cycle(); #1;
    tests++; if (halted !== 1'b1 || retired !== 32'd4 || pc !== 16'h0004 || bp_hit !== 1'b0) begin $display("FAIL bp_step_done: got hlt=%b ret=%0d pc=%h bp=%b exp 1 4 0004 0", halted, retired, pc, bp_hit); fails++; end
  endtask

  task automatic test_wrap();
    bp_addr = 16'h0000; pc_preset_en = 1'b1; pc_preset_val = 16'hFFFF; run = 1'b1; #1;
    next_cycle(); pc_preset_en = 1'b0; run = 1'b0; rom_ack = 1'b1; #1;
    tests++; if (rom_req !== 1'b1 || pc !== 16'hFFFF) begin $display("FAIL wrap_fetch: got req=%b pc=%h exp 1 ffff", rom_req, pc); fails++; end
    next_cycle(); rom_ack = 1'b0; jump = 1'b0; #1;
    tests++; if (pc_inc !== 1'b1 || pc_load !== 1'b0) begin $display("FAIL wrap_exec: got inc=%b ld=%b exp 1 0", pc_inc, pc_load); fails++; end
    next_cycle(); #1;
    tests++; if (halted !== 1'b1 || bp_hit !== 1'b1 || pc !== 16'h0000 || retired !== 32'd5) begin $display("FAIL wrap_bp: got hlt=%b bp=%b pc=%h ret=%0d exp 1 1 0000 5", halted, bp_hit, pc, retired); fails++; end
    bp_en = 1'b0;
  endtask

  task automatic test_restart_reset();
    run = 1'b1; #1;
    next_cycle(); run = 1'b0; rom_ack = 1'b0; #1;
    next_cycle(); restart = 1'b1; #1;
    tests++; if (rom_req !== 1'b1 || exec_en !== 1'b0) begin $display("FAIL restart_wait: got req=%b en=%b exp 1 0", rom_req, exec_en); fails++; end
    next_cycle(); restart = 1'b0; rom_ack = 1'b1; #1;
    tests++; if (pc_reset !== 1'b1 || exec_en !== 1'b0 || rom_req !== 1'b0) begin $display("FAIL restart_to_init: got rst=%b en=%b req=%b exp 1 0 0", pc_reset, exec_en, rom_req); fails++; end
    next_cycle(); #1;
    tests++; if (halted !== 1'b1 || retired !== 32'd0 || bp_hit !== 1'b0 || exec_en !== 1'b0) begin $display("FAIL restart_late_ack: got hlt=%b ret=%0d bp=%b en=%b exp 1 0 0 0", halted, retired, bp_hit, exec_en); fails++; end
    rom_ack = 1'b0; run = 1'b1; #1;
    next_cycle(); run = 1'b0; rom_ack = 1'b1; instr_rd = 16'h7777; #1;
    next_cycle(); rom_ack = 1'b0; jump = 1'b0; #1;
    tests++; if (exec_en !== 1'b1 || instr !== 16'h7777) begin $display("FAIL pre_reset_exec: got en=%b instr=%h exp 1 7777", exec_en, instr); fails++; end
    reset = 1'b1; #1;
    tests++; if (exec_en !== 1'b0 || pc_inc !== 1'b0 || instr !== 16'h0000 || retired !== 32'd0) begin $display("FAIL async_reset: got en=%b inc=%b instr=%h ret=%0d exp 0 0 0000 0", exec_en, pc_inc, instr, retired); fails++; end
    reset = 1'b0; #1;
    tests++; if (pc_reset !== 1'b1 || exec_en !== 1'b0) begin $display("FAIL async_reset_init: got rst=%b en=%b exp 1 0", pc_reset, exec_en); fails++; end
    next_cycle(); #1;
    tests++; if (halted !== 1'b1 || retired !== 32'd0) begin $display("FAIL async_reset_halt: got hlt=%b ret=%0d exp 1 0", halted, retired); fails++; end
  endtask

  initial begin
    test_reset();
    test_step_late_ack();
    test_run_jump();
    test_breakpoint();
    test_wrap();
    test_restart_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
